fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the CPU core. It replaces the bare PC register, PC+4 adder and PC-source mux with a sequential unit that holds the fetch PC and issues pipelined requests to instruction memory. Returned words are buffered in order in a small reservation queue and presented to decode over a valid/ready handshake. Branch/jump redirects flush the queue and discard stale in-flight responses.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: holds the fetch PC, issues pipelined memory requests,
// buffers in-order responses in a small reservation queue and hands them to decode.
module fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic               clk_i,
    input  logic               rst_i,
    output logic               imem_req_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic               imem_ack_i,
    input  logic               imem_rvalid_i,
    input  logic [INSTR_W-1:0] imem_rdata_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    output logic               instr_valid_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  instr_pc_o,
    input  logic               instr_ready_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] DEPTH_C = SUM_W'(DEPTH);

    logic [ADDR_W-1:0]  fetch_pc_r;
    logic [ADDR_W-1:0]  pc_r    [DEPTH];
    logic [INSTR_W-1:0] instr_r [DEPTH];
    logic [DEPTH-1:0]   filled_r;
    logic [PTR_W-1:0]   head_r;
    logic [PTR_W-1:0]   tail_r;
    logic [PTR_W-1:0]   fill_r;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   unfilled_r;
    logic [CNT_W-1:0]   discard_r;

    logic [SUM_W-1:0]   credit_s;
    logic               reserve_s;
    logic               fill_s;
    logic               drop_s;
    logic               pop_s;
    logic [CNT_W-1:0]   redir_sum_s;
    logic [CNT_W-1:0]   redir_discard_s;
    logic               unused_s;

    assign unused_s = ^redirect_pc_i[1:0];

    // Request credit, handshake qualifiers and head-of-queue presentation.
    always_comb begin
        credit_s      = {1'b0, count_r} + {1'b0, discard_r};
        imem_req_o    = (credit_s < DEPTH_C) & ~redirect_i;
        imem_addr_o   = fetch_pc_r;
        reserve_s     = imem_req_o & imem_ack_i;
        drop_s        = imem_rvalid_i & (discard_r != {CNT_W{1'b0}});
        fill_s        = imem_rvalid_i & (discard_r == {CNT_W{1'b0}}) & (unfilled_r != {CNT_W{1'b0}});
        instr_valid_o = filled_r[head_r] & (count_r != {CNT_W{1'b0}});
        instr_o       = instr_r[head_r];
        instr_pc_o    = pc_r[head_r];
        pop_s         = instr_valid_o & instr_ready_i;
    end

    // Stale responses still owed after a redirect; one arriving this cycle is already retired.
    always_comb begin
        redir_sum_s = discard_r + unfilled_r;
        if (imem_rvalid_i && (redir_sum_s != {CNT_W{1'b0}})) begin
            redir_discard_s = redir_sum_s - CNT_W'(1);
        end else begin
            redir_discard_s = redir_sum_s;
        end
    end

    // Fetch PC, queue storage, pointers and counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_r <= RESET_PC;
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]    <= {ADDR_W{1'b0}};
                instr_r[i] <= {INSTR_W{1'b0}};
            end
            filled_r   <= {DEPTH{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            fill_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            unfilled_r <= {CNT_W{1'b0}};
            discard_r  <= {CNT_W{1'b0}};
        end else if (redirect_i) begin
            fetch_pc_r <= {redirect_pc_i[ADDR_W-1:2], 2'b00};
            for (int i = 0; i < DEPTH; i++) begin
                pc_r[i]    <= {ADDR_W{1'b0}};
                instr_r[i] <= {INSTR_W{1'b0}};
            end
            filled_r   <= {DEPTH{1'b0}};
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            fill_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            unfilled_r <= {CNT_W{1'b0}};
            discard_r  <= redir_discard_s;
        end else begin
            // Reserve, fill and pop touch distinct entries whenever they coincide.
            if (reserve_s) begin
                pc_r[tail_r]     <= fetch_pc_r;
                filled_r[tail_r] <= 1'b0;
                tail_r           <= tail_r + PTR_W'(1);
                fetch_pc_r       <= fetch_pc_r + ADDR_W'(4);
            end
            if (fill_s) begin
                instr_r[fill_r]  <= imem_rdata_i;
                filled_r[fill_r] <= 1'b1;
                fill_r           <= fill_r + PTR_W'(1);
            end
            if (drop_s) begin
                discard_r <= discard_r - CNT_W'(1);
            end else begin
                discard_r <= discard_r;
            end
            if (pop_s) begin
                pc_r[head_r]     <= {ADDR_W{1'b0}};
                instr_r[head_r]  <= {INSTR_W{1'b0}};
                filled_r[head_r] <= 1'b0;
                head_r           <= head_r + PTR_W'(1);
            end
            count_r    <= count_r + CNT_W'(reserve_s) - CNT_W'(pop_s);
            unfilled_r <= unfilled_r + CNT_W'(reserve_s) - CNT_W'(fill_s);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised bench for fetch_unit: a bench-side memory answers requests and a
// queue-based reference model predicts every output on every cycle.
module tb_fetch_unit;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b0;

    fetch_unit #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk_i(clk), .rst_i(rst),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_ack_i(imem_ack),
        .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
        .redirect_i(redirect), .redirect_pc_i(redirect_pc),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .instr_ready_i(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] pc; logic [31:0] word; bit filled; } ent_t;
    typedef struct { logic [31:0] addr; int cyc; } pend_t;

    ent_t        mq[$];
    pend_t       pend[$];
    logic [31:0] pops[$];
    logic [31:0] m_pc = RST_PC;
    int          m_discard = 0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          acks = 0;
    logic        last_req = 1'b0;
    logic [31:0] last_addr = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        if (i < pops.size()) return pops[i];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        imem_ack = 1'b0; imem_rvalid = 1'b0; redirect = 1'b0; instr_ready = 1'b0;
        #1;
        chk("rst_valid", {31'h0, instr_valid}, 32'h0);
        chk("rst_addr", imem_addr, RST_PC);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        mq.delete(); pend.delete();
        m_pc = RST_PC; m_discard = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input bit ack_en, input bit rv_en, input bit redir,
                        input logic [31:0] rpc, input bit rdy);
        bit          exp_req, do_rv, dut_ack, pop, done;
        logic [31:0] rv_data;
        int          nd;
        @(negedge clk);
        imem_ack = ack_en; redirect = redir; redirect_pc = rpc; instr_ready = rdy;
        do_rv = 1'b0; rv_data = $urandom;
        if (rv_en && pend.size() > 0 && pend[0].cyc < cyc) begin
            do_rv = 1'b1;
            rv_data = mem_word(pend[0].addr);
            pend.delete(0);
        end
        imem_rvalid = do_rv; imem_rdata = rv_data;
        #1;
        exp_req = (mq.size() + m_discard < DEPTH) && !redir;
        chk("imem_req", {31'h0, imem_req}, {31'h0, exp_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'h0, instr_valid}, {31'h0, (mq.size() > 0 && mq[0].filled)});
        chk("instr", instr, (mq.size() > 0) ? mq[0].word : 32'h0);
        chk("instr_pc", instr_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
        last_req = imem_req; last_addr = imem_addr;
        dut_ack = imem_req && ack_en;
        if (dut_ack) acks++;
        if (instr_valid && rdy && !redir) pops.push_back(instr_pc);
        @(posedge clk);
        if (dut_ack) pend.push_back('{imem_addr, cyc});
        cyc++;
        // Reference model update for this edge.
        if (redir) begin
            nd = m_discard;
            foreach (mq[i]) if (!mq[i].filled) nd++;
            if (do_rv && nd > 0) nd--;
            m_discard = nd;
            mq.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            pop = (mq.size() > 0) && mq[0].filled && rdy;
            if (do_rv) begin
                if (m_discard > 0) begin
                    m_discard--;
                end else begin
                    done = 1'b0;
                    foreach (mq[i]) begin
                        if (!done && !mq[i].filled) begin
                            mq[i].word = rv_data;
                            mq[i].filled = 1'b1;
                            done = 1'b1;
                        end
                    end
                end
            end
            if (pop) mq.delete(0);
            if (exp_req && ack_en) begin
                mq.push_back('{m_pc, 32'h0, 1'b0});
                m_pc = m_pc + 32'h4;
            end
        end
    endtask

    initial begin
        do_reset();

        // Streaming from the reset PC across the address wrap.
        repeat (8) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("stream_count", pops.size(), 32'd6);
        chk("stream_pc0", pop_at(0), 32'hFFFF_FFF8);
        chk("stream_pc1", pop_at(1), 32'hFFFF_FFFC);
        chk("stream_pc2", pop_at(2), 32'h0000_0000);
        chk("stream_pc3", pop_at(3), 32'h0000_0004);

        // Decode stalled: exactly DEPTH acks, then drain in order.
        step(1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
        acks = 0; pops.delete();
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("full_acks", acks, 32'd4);
        chk("full_req", {31'h0, last_req}, 32'h0);
        repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("drain_pc0", pop_at(0), 32'h0);
        chk("drain_pc1", pop_at(1), 32'h4);
        chk("drain_pc2", pop_at(2), 32'h8);
        chk("drain_pc3", pop_at(3), 32'hC);
        chk("drain_pc4", pop_at(4), 32'h10);

        // Redirect to an unaligned target with requests in flight.
        repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h1003, 1'b1);
        pops.delete();
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_addr", last_addr, 32'h1000);
        repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("redir_first_pc", pop_at(0), 32'h1000);

        // Redirect coinciding with a response and a pop.
        do_reset();
        repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 32'h5000, 1'b1);
        pops.delete();
        repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("coinc_first_pc", pop_at(0), 32'h5000);

        // Back-to-back redirects with the full depth in flight.
        do_reset();
        repeat (4) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h3000, 1'b0);
        step(1'b0, 1'b0, 1'b1, 32'h4000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("double_redir_req", {31'h0, last_req}, 32'h0);
        pops.delete();
        repeat (20) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("double_redir_pc", pop_at(0), 32'h4000);

        // Randomised traffic, including occasional mid-stream resets.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 15) == 0,
                     ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom,
                     $urandom_range(0, 2) != 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
